// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM state codes and width helpers.
package fifo_write_arbiter_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_BURST = 1'b1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Increment with wrap to zero at n, used for the round-robin pointer.
    function automatic int unsigned wrap_inc(input int unsigned value, input int unsigned n);
        return (value + 1 == n) ? 0 : value + 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_picker.sv
// Rotating first-one finder: returns the first set request at or after base, wrapping.
module rr_priority_picker
    import fifo_write_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [clog2(N)-1:0]   base,
    output logic                  valid,
    output logic [clog2(N)-1:0]   idx
);

    localparam int IW = clog2(N);

    int unsigned pos;

    // Scan from farthest to nearest so the position closest to base is written last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int unsigned k = N; k > 0; k--) begin
            pos = (32'(base) + k - 1) % N;
            if (req[pos]) begin
                valid = 1'b1;
                idx   = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin write-port arbiter with burst locking in front of a SyncFIFO.
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int BITWIDTH  = 5,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*BITWIDTH-1:0]   reqData,
    output logic [N_REQ-1:0]            gnt,
    input  logic                        fifoFull,
    input  logic                        fifoREn,
    output logic                        fifoWEn,
    output logic [BITWIDTH-1:0]         fifoDIn,
    output logic                        busy,
    output logic [clog2(N_REQ)-1:0]     owner
);

    localparam int IW = clog2(N_REQ);
    localparam int CW = clog2(MAX_BURST) + 1;

    logic          state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] sel;
    logic          owner_req;
    logic          cand;
    logic          space;
    logic          accept;
    logic [CW-1:0] cnt_inc;
    logic [BITWIDTH-1:0] sel_word;

    rr_priority_picker #(
        .N (N_REQ)
    ) u_picker (
        .req   (req),
        .base  (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        owner_req = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (IW'(i) == owner_q) begin
                owner_req = req[i];
            end
        end
    end

    // During a burst only the owner is eligible; otherwise the rotating picker decides.
    always_comb begin
        sel    = (state_q == ST_BURST) ? owner_q : pick_idx;
        cand   = (state_q == ST_BURST) ? owner_req : pick_valid;
        space  = ~fifoFull | fifoREn;
        accept = cand & space & ~rst;
    end

    always_comb begin
        sel_word = '0;
        gnt      = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (IW'(i) == sel) begin
                sel_word = reqData[i*BITWIDTH +: BITWIDTH];
                gnt[i]   = accept;
            end
        end
        fifoWEn = accept;
        fifoDIn = accept ? sel_word : '0;
        busy    = (state_q == ST_BURST);
        owner   = owner_q;
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        cnt_inc  = cnt_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    owner_d = sel;
                    if (MAX_BURST == 1) begin
                        rr_ptr_d = IW'(wrap_inc(32'(sel), N_REQ));
                    end else begin
                        cnt_d   = CW'(1);
                        state_d = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                if (!owner_req) begin
                    rr_ptr_d = IW'(wrap_inc(32'(owner_q), N_REQ));
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end else if (accept) begin
                    if (cnt_inc == CW'(MAX_BURST)) begin
                        rr_ptr_d = IW'(wrap_inc(32'(owner_q), N_REQ));
                        cnt_d    = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
